// File: rtl/cpu_ctrl_fsm.sv
// Instruction-cycle sequencer for the 8-bit accumulator CPU.
// Walks each 2-byte instruction through eight states and decodes the control strobes.
//
// state       | meaning
// S0 FETCH_HI | read first instruction byte into IR
// S1 FETCH_LO | read second byte, advance PC
// S2 IDLE     | opcode settles
// S3 DECODE   | advance PC, or park here on HLT
// S4 OPERAND  | ALU evaluate / store setup / jump target
// S5 EXEC     | capture ALU result, write memory, jump, or sample zero for SKZ
// S6 HOLD     | keep store data on the bus one cycle past wr
// S7 NEXT     | extra PC advance when SKZ skipped
module cpu_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       alu_ena,
  output logic       datactl_ena,
  output logic       halt,
  output logic [2:0] state
);

  localparam logic [2:0] HLT  = 3'b000;
  localparam logic [2:0] SKZ  = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] ANDD = 3'b011;
  localparam logic [2:0] XORR = 3'b100;
  localparam logic [2:0] LDA  = 3'b101;
  localparam logic [2:0] STO  = 3'b110;
  localparam logic [2:0] JMP  = 3'b111;

  typedef enum logic [2:0] {
    S0_FETCH_HI = 3'd0,
    S1_FETCH_LO = 3'd1,
    S2_IDLE     = 3'd2,
    S3_DECODE   = 3'd3,
    S4_OPERAND  = 3'd4,
    S5_EXEC     = 3'd5,
    S6_HOLD     = 3'd6,
    S7_NEXT     = 3'd7
  } state_t;

  state_t state_q, state_d;
  logic   skip_q, skip_d;
  logic   alu_op;

  assign alu_op = (opcode == ADD) || (opcode == ANDD) || (opcode == XORR) || (opcode == LDA);
  assign state  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0_FETCH_HI;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Unknown opcodes fall through the else branches, giving NOP (SKZ, zero=0) timing.
  always_comb begin
    state_d = state_t'(state_q + 3'd1);
    skip_d  = skip_q;
    case (state_q)
      S3_DECODE: begin
        if (opcode == HLT) state_d = S3_DECODE;
        else               state_d = S4_OPERAND;
      end
      S5_EXEC: begin
        if (opcode == SKZ) skip_d = zero;
      end
      S7_NEXT: begin
        skip_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    alu_ena     = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    if (!rst) begin
      case (state_q)
        S0_FETCH_HI: begin
          rd      = 1'b1;
          load_ir = 1'b1;
        end
        S1_FETCH_LO: begin
          rd      = 1'b1;
          load_ir = 1'b1;
          inc_pc  = 1'b1;
        end
        S3_DECODE: begin
          if (opcode == HLT) halt   = 1'b1;
          else               inc_pc = 1'b1;
        end
        S4_OPERAND: begin
          if (alu_op) begin
            rd      = 1'b1;
            alu_ena = 1'b1;
          end else if (opcode == STO) begin
            datactl_ena = 1'b1;
          end else if (opcode == JMP) begin
            load_pc = 1'b1;
          end
        end
        S5_EXEC: begin
          if (alu_op) begin
            rd       = 1'b1;
            load_acc = 1'b1;
          end else if (opcode == SKZ) begin
            inc_pc = zero;
          end else if (opcode == STO) begin
            wr          = 1'b1;
            datactl_ena = 1'b1;
          end else if (opcode == JMP) begin
            load_pc = 1'b1;
          end
        end
        S6_HOLD: begin
          if (opcode == STO) datactl_ena = 1'b1;
        end
        S7_NEXT: begin
          if ((opcode == SKZ) && skip_q) inc_pc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: directed instruction runs plus random traffic against an
// instruction-level reference model (phase counter, per-opcode strobe table, PC-advance totals).
module tb_cpu_ctrl_fsm;

  localparam logic [2:0] HLT  = 3'd0;
  localparam logic [2:0] SKZ  = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] ANDD = 3'd3;
  localparam logic [2:0] XORR = 3'd4;
  localparam logic [2:0] LDA  = 3'd5;
  localparam logic [2:0] STO  = 3'd6;
  localparam logic [2:0] JMP  = 3'd7;

  localparam int B_RD = 8, B_WR = 7, B_IR = 6, B_INC = 5, B_LPC = 4;
  localparam int B_ACC = 3, B_ALU = 2, B_DCTL = 1, B_HALT = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_ena, datactl_ena, halt;
  logic [2:0] state;

  cpu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .rd(rd), .wr(wr), .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc),
    .load_acc(load_acc), .alu_ena(alu_ena), .datactl_ena(datactl_ena),
    .halt(halt), .state(state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: instruction phase, whether it is known, zero seen at EXEC
  int         m_ph = 0;
  bit         m_valid = 1'b0;
  logic       m_zs5 = 1'b0;
  int         ins_incs = 0;
  int         ins_len = 0;
  logic [2:0] ins_op = ADD;

  logic [8:0] obs, exp_v;
  logic [8:0] tr [8];
  logic [2:0] tr_st [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [8:0] model_out(input logic r, input logic [2:0] op, input logic z);
    logic [8:0] v;
    bit is_alu;
    v = '0;
    is_alu = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    if (!r && m_valid) begin
      case (m_ph)
        0: begin v[B_RD] = 1; v[B_IR] = 1; end
        1: begin v[B_RD] = 1; v[B_IR] = 1; v[B_INC] = 1; end
        3: if (op == HLT) v[B_HALT] = 1; else v[B_INC] = 1;
        4: if (is_alu) begin v[B_RD] = 1; v[B_ALU] = 1; end
           else if (op == STO) v[B_DCTL] = 1;
           else if (op == JMP) v[B_LPC] = 1;
        5: if (is_alu) begin v[B_RD] = 1; v[B_ACC] = 1; end
           else if (op == SKZ) v[B_INC] = z;
           else if (op == STO) begin v[B_WR] = 1; v[B_DCTL] = 1; end
           else if (op == JMP) v[B_LPC] = 1;
        6: if (op == STO) v[B_DCTL] = 1;
        7: if (op == SKZ && m_zs5) v[B_INC] = 1;
        default: ;
      endcase
    end
    return v;
  endfunction

  function automatic logic [7:0] lane(input int b);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = tr[i][b];
    return v;
  endfunction

  task automatic cycle(input logic r, input logic [2:0] op, input logic z);
    rst = r; opcode = op; zero = z;
    @(negedge clk);
    obs   = {rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_ena, datactl_ena, halt};
    exp_v = model_out(r, op, z);
    check("strobes", obs, exp_v);
    if (m_valid) check("state", state, m_ph[2:0]);
    check("invariants", {(rd && wr), (load_pc && inc_pc), (alu_ena && state != 3'd4),
                         (halt && state != 3'd3)}, 4'b0);
    if (m_valid) begin
      tr[m_ph]    = obs;
      tr_st[m_ph] = state;
    end
    if (!r) begin
      ins_incs += int'(inc_pc);
      ins_len++;
    end
    @(posedge clk);
    if (r) begin
      m_ph = 0; m_valid = 1'b1; m_zs5 = 1'b0; ins_incs = 0; ins_len = 0;
    end else if (m_valid) begin
      if (m_ph == 5) begin m_zs5 = z; ins_op = op; end
      if (m_ph == 3 && op == HLT) begin
        m_ph = 3;
      end else if (m_ph == 7) begin
        check("instr_len", ins_len, 8);
        check("pc_advance", ins_incs, (ins_op == SKZ && m_zs5) ? 4 : 2);
        m_ph = 0; m_zs5 = 1'b0; ins_incs = 0; ins_len = 0;
      end else begin
        m_ph++;
      end
    end
    #1;
  endtask

  // one full instruction; opcode is junk before S2, zero is junk outside S5
  task automatic run(input logic [2:0] op, input logic z);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, (i < 2) ? 3'($urandom) : op, (i == 5) ? z : 1'($urandom));
  endtask

  function automatic int ones(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  logic [2:0] cur_op;
  logic       r_rand;

  initial begin
    rst = 1'b1; opcode = ADD; zero = 1'b0;
    cycle(1'b1, ADD, 1'b0);
    cycle(1'b1, ADD, 1'b0);
    check("reset_state", state, 3'd0);

    run(ADD, 1'b0);
    check("add_s0", {tr[0][B_RD], tr[0][B_IR]}, 2'b11);
    check("add_s1_inc", tr[1][B_INC], 1'b1);
    check("add_s3_inc", tr[3][B_INC], 1'b1);
    check("add_s4", {tr[4][B_ALU], tr[4][B_RD]}, 2'b11);
    check("add_s5_acc", tr[5][B_ACC], 1'b1);
    check("add_incs", ones(lane(B_INC)), 2);
    check("add_wrap", state, 3'd0);

    run(SKZ, 1'b1);
    check("skz1_inc_lane", lane(B_INC), 8'b1010_1010);
    run(SKZ, 1'b0);
    check("skz0_inc_lane", lane(B_INC), 8'b0000_1010);
    check("skz0_s7", tr[7][B_INC], 1'b0);

    run(STO, 1'b1);
    check("sto_dctl", lane(B_DCTL), 8'b0111_0000);
    check("sto_wr", lane(B_WR), 8'b0010_0000);
    check("sto_rd_late", lane(B_RD) & 8'b1111_1100, 8'h00);

    run(JMP, 1'b0);
    check("jmp_lpc", lane(B_LPC), 8'b0011_0000);
    check("jmp_inc_late", lane(B_INC) & 8'b1111_0000, 8'h00);

    for (int i = 0; i < 4; i++) cycle(1'b0, (i < 2) ? 3'($urandom) : HLT, 1'($urandom));
    for (int i = 0; i < 22; i++) begin
      cycle(1'b0, HLT, 1'($urandom));
      check("hlt_hold", {state, halt, inc_pc}, {3'd3, 1'b1, 1'b0});
    end
    cycle(1'b1, HLT, 1'b0);
    cycle(1'b0, ADD, 1'b0);
    check("hlt_release", {tr_st[0], tr[0][B_HALT], tr[0][B_RD]}, {3'd0, 1'b0, 1'b1});
    for (int i = 1; i < 8; i++) cycle(1'b0, (i < 2) ? 3'($urandom) : ADD, 1'b0);

    for (int i = 0; i < 5; i++) cycle(1'b0, SKZ, 1'b1);
    cycle(1'b1, SKZ, 1'b1);
    run(ADD, 1'b1);
    check("rst_mid_s0", tr_st[0], 3'd0);
    check("rst_mid_s7", tr[7][B_INC], 1'b0);
    check("rst_mid_incs", ones(lane(B_INC)), 2);

    cur_op = ADD;
    for (int k = 0; k < 3000; k++) begin
      r_rand = ($urandom_range(0, 59) == 0) ||
               (m_ph == 3 && cur_op == HLT && $urandom_range(0, 5) == 0);
      if (m_ph == 2) cur_op = ($urandom_range(0, 9) == 0) ? HLT : 3'($urandom_range(1, 7));
      cycle(r_rand, (m_ph < 2) ? 3'($urandom) : cur_op, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Instruction-cycle controller for the 8-bit accumulator CPU.
- An 8-state sequencer (S0..S7) walks each 2-byte instruction through fetch, decode, operand and execute. It drives the control strobes for the PC, the instruction register, the accumulator, memory and the data bus.
- It also issues the one-cycle enable that advances the ALU, then consumes the ALU's zero flag.
- Sits directly upstream of the ALU: it supplies alu_ena (gates the ALU clock) and the load_acc strobe that captures alu_out.

Parameters:
- HLT, 3'b000, halt opcode
- SKZ, 3'b001, skip-if-zero opcode
- ADD, 3'b010, add opcode
- ANDD, 3'b011, and opcode
- XORR, 3'b100, xor opcode
- LDA, 3'b101, load opcode
- STO, 3'b110, store opcode
- JMP, 3'b111, jump opcode

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- opcode  in  3  opcode field from the instruction register; valid from S2 onward
- zero  in  1  accumulator-zero flag from the ALU
- rd  out  1  memory read strobe
- wr  out  1  memory write strobe
- load_ir  out  1  load instruction register byte
- inc_pc  out  1  increment program counter
- load_pc  out  1  load PC from operand address
- load_acc  out  1  accumulator captures alu_out
- alu_ena  out  1  one-cycle ALU evaluate enable
- datactl_ena  out  1  drive accumulator onto data bus
- halt  out  1  CPU halted
- state  out  3  current state index, for debug

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- While rst=1 at a posedge: state<=S0, skip_q<=0. While rst is high, all strobe outputs are forced to 0 combinationally.
- Outputs are a combinational decode of state_q, opcode and skip_q/zero. They are glitch-tolerant and are sampled by consumers on the next posedge.
- The sequence is S0->S1->...->S7->S0, one state per clock, except for HLT.
- Per-state outputs (unlisted outputs are 0):
  - S0 FETCH_HI: rd=1, load_ir=1.
  - S1 FETCH_LO: rd=1, load_ir=1, inc_pc=1.
  - S2 IDLE: all 0. Opcode becomes stable here.
  - S3 DECODE:
    - HLT: halt=1, inc_pc=0; state holds S3 until rst.
    - All other opcodes: inc_pc=1, next state S4.
  - S4 OPERAND:
    - ADD/ANDD/XORR/LDA: rd=1, alu_ena=1.
    - STO: datactl_ena=1.
    - JMP: load_pc=1.
    - SKZ: nothing.
  - S5 EXEC:
    - ADD/ANDD/XORR/LDA: rd=1, load_acc=1. This captures the ALU result registered one cycle after alu_ena.
    - SKZ: inc_pc=zero. On this edge, skip_q<=zero.
    - STO: wr=1, datactl_ena=1.
    - JMP: load_pc=1.
  - S6 HOLD: STO: datactl_ena=1, wr=0 (data held one cycle past wr).
  - S7 NEXT: SKZ and skip_q=1: inc_pc=1 (second byte of the skipped instruction). On leaving S7, skip_q<=0.
- Latency:
  - Exactly 8 clocks per non-HLT instruction.
  - alu_ena is asserted in S4, and load_acc in S5 of the same instruction.
  - For a non-HLT instruction, the PC advances by 2; SKZ with zero=1 advances it by 4.
- Invariants:
  - wr and rd are never high together.
  - load_pc and inc_pc are never high together.
  - alu_ena is only high in S4.
  - halt is only high in S3.
- zero is sampled only in S5. Changes to zero in other states have no effect.
- Unknown or X opcode is treated as a NOP: same timing as SKZ with zero=0.
- Reset mid-instruction (any state, including halted S3): the next cycle is S0 with halt=0, skip_q=0 and no residual strobes.
- state output: S0=0 ... S7=7.

Test Plan:
- Reset then run with opcode=ADD, zero=0:
  - Cycle 1 (S0): rd=1, load_ir=1.
  - Cycle 2 (S1): inc_pc=1.
  - Cycle 4 (S3): inc_pc=1.
  - Cycle 5 (S4): alu_ena=1, rd=1.
  - Cycle 6 (S5): load_acc=1.
  - Cycle 9: back to S0.
  - Total inc_pc pulses = 2.
- opcode=SKZ with zero=1 at S5 -> inc_pc high in S1, S3, S5 and S7 (4 pulses). With zero=0 -> 2 pulses and S7 has inc_pc=0.
- opcode=STO -> datactl_ena high in S4, S5 and S6; wr high only in S5; rd never high after S1.
- opcode=JMP -> load_pc high in S4 and S5; inc_pc low in S4–S7.
- opcode=HLT -> state sticks at 3 with halt=1 for 20+ cycles and no inc_pc. Asserting rst for 1 cycle -> state=0, halt=0, rd=1.
- Assert rst during S5 of an SKZ with zero=1 -> next cycle is S0; in the following instruction, S7 shows no extra inc_pc.
